// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - keypad debouncer and two-operand signed entry FSM
// Debounced keys build operand A then B; the DONE state holds the pair until op_ready or clear.
module operand_entry #(
  parameter int STABLE_HITS    = 3,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [3:0] key_value,
  input  logic       key_pressed,
  input  logic [2:0] is_sign_key,
  input  logic       op_ready,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic       op_valid,
  output logic       key_strobe,
  output logic [1:0] entry_state
);

  localparam int HW = $clog2(STABLE_HITS + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [HW-1:0] HIT_MAX = HW'(STABLE_HITS);
  localparam logic [RW-1:0] REL_MAX = RW'(RELEASE_CYCLES);

  localparam logic [2:0] CLS_DIGIT = 3'b000;
  localparam logic [2:0] CLS_MINUS = 3'b100;
  localparam logic [2:0] CLS_PLUS  = 3'b010;
  localparam logic [2:0] CLS_ENTER = 3'b001;
  localparam logic [2:0] CLS_CLEAR = 3'b111;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    DONE    = 2'b10
  } state_t;

  logic [6:0]    tuple_q;
  logic [HW-1:0] hit_cnt;
  logic [RW-1:0] rel_cnt;
  logic          locked;
  logic [3:0]    acc_key;
  logic [2:0]    acc_cls;
  logic [6:0]    cand;

  state_t     state;
  logic [6:0] mag_a, mag_b;
  logic       sign_a, sign_b;
  logic [1:0] cnt_a, cnt_b;

  assign cand = {key_value, is_sign_key};

  // Debounce: accept on the STABLE_HITS-th matching hit, then lock until a release gap.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      tuple_q    <= '0;
      hit_cnt    <= '0;
      rel_cnt    <= '0;
      locked     <= 1'b0;
      key_strobe <= 1'b0;
      acc_key    <= '0;
      acc_cls    <= '0;
    end else begin
      key_strobe <= 1'b0;
      if (key_pressed) begin
        rel_cnt <= '0;
        if (!locked) begin
          if (cand == tuple_q) begin
            if (hit_cnt != HIT_MAX) hit_cnt <= hit_cnt + 1'b1;
            if (hit_cnt == HIT_MAX - 1'b1) begin
              locked     <= 1'b1;
              key_strobe <= 1'b1;
              acc_key    <= key_value;
              acc_cls    <= is_sign_key;
            end
          end else begin
            tuple_q <= cand;
            hit_cnt <= HW'(1);
            if (STABLE_HITS == 1) begin
              locked     <= 1'b1;
              key_strobe <= 1'b1;
              acc_key    <= key_value;
              acc_cls    <= is_sign_key;
            end
          end
        end
      end else if (rel_cnt != REL_MAX) begin
        rel_cnt <= rel_cnt + 1'b1;
        if (rel_cnt == REL_MAX - 1'b1) begin
          locked  <= 1'b0;
          hit_cnt <= '0;
        end
      end
    end
  end

  function automatic logic [6:0] shift_in(input logic [6:0] m, input logic [3:0] d);
    return m * 7'd10 + {3'b000, d};
  endfunction

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      state  <= ENTER_A;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt_a  <= '0;
      cnt_b  <= '0;
    end else if ((state == DONE && op_ready) || (key_strobe && acc_cls == CLS_CLEAR)) begin
      state  <= ENTER_A;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt_a  <= '0;
      cnt_b  <= '0;
    end else if (key_strobe && state != DONE) begin
      case (acc_cls)
        CLS_DIGIT: begin
          if (state == ENTER_A && cnt_a < 2'd2) begin
            mag_a <= shift_in(mag_a, acc_key);
            cnt_a <= cnt_a + 1'b1;
          end else if (state == ENTER_B && cnt_b < 2'd2) begin
            mag_b <= shift_in(mag_b, acc_key);
            cnt_b <= cnt_b + 1'b1;
          end
        end
        CLS_MINUS: begin
          if (state == ENTER_A) sign_a <= 1'b1;
          else                  sign_b <= 1'b1;
        end
        CLS_PLUS: begin
          if (state == ENTER_A) sign_a <= 1'b0;
          else                  sign_b <= 1'b0;
        end
        CLS_ENTER: state <= (state == ENTER_A) ? ENTER_B : DONE;
        default: ;
      endcase
    end
  end

  // -0 naturally folds to 8'h00 since magnitude 0 negates to 0.
  assign operand_a   = sign_a ? (8'd0 - {1'b0, mag_a}) : {1'b0, mag_a};
  assign operand_b   = sign_b ? (8'd0 - {1'b0, mag_b}) : {1'b0, mag_b};
  assign op_valid    = (state == DONE);
  assign entry_state = state;

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have parameter STABLE_HITS, default 3: consecutive identical keypad hits required to accept a key.
REQ-002 The block SHALL have parameter RELEASE_CYCLES, default 8: consecutive cycles with key_pressed=0 that count as key release.
REQ-003 The block SHALL have port slow_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port key_value  input  4  decoded key code from the keypad row scanner.
REQ-006 The block SHALL have port key_pressed  input  1  scanner hit flag; key_value/is_sign_key valid only while high.
REQ-007 The block SHALL have port is_sign_key  input  3  key class: 000 digit, 100 "*" (minus), 010 "#" (plus), 001 "A" (enter), 011 "B"/"C" (ignored), 111 "D" (clear).
REQ-008 The block SHALL have port op_ready  input  1  downstream multiplier accepts the operand pair.
REQ-009 The block SHALL have port operand_a  output  8  signed two's-complement operand A.
REQ-010 The block SHALL have port operand_b  output  8  signed two's-complement operand B.
REQ-011 The block SHALL have port op_valid  output  1  operand pair complete and stable.
REQ-012 The block SHALL have port key_strobe  output  1  one-cycle pulse per accepted key.
REQ-013 The block SHALL have port entry_state  output  2  00 ENTER_A, 01 ENTER_B, 10 DONE.

Function
REQ-014 Hit SHALL be a cycle with key_pressed=1; the candidate tuple SHALL be {key_value, is_sign_key}.
REQ-015 Hit counter: a hit matching the stored tuple SHALL increment the counter (saturating); a non-matching hit SHALL store the new tuple and set the counter to 1; cycles without a hit SHALL NOT reset it.
REQ-016 The release counter SHALL count consecutive cycles with key_pressed=0 and clear on any hit; reaching RELEASE_CYCLES SHALL clear the lock and hit counter.
REQ-017 Acceptance: the edge sampling the STABLE_HITS-th matching hit while unlocked SHALL set the lock and raise key_strobe for exactly the next cycle.
REQ-018 While locked, hits of any tuple SHALL be ignored; no further acceptance until release.
REQ-019 The accepted key SHALL take effect at the edge ending the key_strobe cycle (effect visible 2 cycles after the final hit edge).
REQ-020 FSM states SHALL be ENTER_A, ENTER_B, DONE; each entry state holds a 7-bit magnitude, a sign flag and a 2-bit digit count.
REQ-021 Digit in ENTER_A/ENTER_B: if digit count < 2, magnitude SHALL become magnitude*10 + key_value and count increments; third and later digits SHALL be ignored.
REQ-022 "*" SHALL set the sign flag and "#" SHALL clear it, at any point during entry of the current operand.
REQ-023 The current operand output SHALL track entry live: sign ? -magnitude : magnitude in 8-bit two's complement; -0 SHALL be 8'h00.
REQ-024 "A" SHALL move ENTER_A -> ENTER_B and ENTER_B -> DONE; committing with zero digits SHALL yield operand 0.
REQ-025 op_valid SHALL be high exactly while in DONE; operands SHALL be frozen in DONE; digit, sign, "A", "B", "C" keys SHALL be ignored in DONE.
REQ-026 In DONE, op_ready=1 at an edge SHALL drop op_valid, clear both operands, sign flags and counts, and go to ENTER_A.
REQ-027 "D" in any state SHALL clear both operands, sign flags and counts, drop op_valid and go to ENTER_A; simultaneous "D" effect and op_ready give the same result.
REQ-028 "B"/"C" SHALL produce key_strobe but no other effect.

Reset
REQ-029 rst=0 SHALL immediately force: state ENTER_A, operand_a=operand_b=8'h00, op_valid=0, key_strobe=0, entry_state=00, counters, lock and stored tuple cleared.
REQ-030 Reset asserted mid-entry or in DONE SHALL discard all entry with no op_valid pulse; after release the first key requires STABLE_HITS fresh hits.

Verification
REQ-031 Keys 4,2,A then 1,7,A (each 3 hits, then 8 idle) -> operand_a=8'h2A, operand_b=8'h11, op_valid=1, entry_state=10.
REQ-032 A: *,9,9,A; B: #,5,A -> operand_a=8'h9D (-99), operand_b=8'h05; op_ready=1 one cycle -> op_valid=0, operands 00, entry_state=00.
REQ-033 Digit 3 with 2 hits, 1 hit of 5, 3 hits of 5 -> exactly one key_strobe, magnitude 5.
REQ-034 Hold digit 7 for 20 hits, no release -> one key_strobe; 8 idle cycles then 3 hits -> second acceptance, operand 8'h4D (77).
REQ-035 Digits 1,2,3 then A -> operand_a=8'h0C (12); "D" in DONE -> op_valid=0, all outputs 00, entry_state=00.
REQ-036 rst=0 asynchronously while in ENTER_B -> all outputs 00 before the next slow_clk edge.
